// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display scanner: GAP/ON sequencer with frame-aligned value updates.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always lit).
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int GAP        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    val_valid,
  output logic                    val_ready,
  output logic [3:0]              digit_nib,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_done
);

  localparam int VW   = 4 * NUM_DIGITS;
  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2((MAXC > 1) ? MAXC : 2);
  localparam int IW   = $clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2);

  typedef enum logic {ST_GAP = 1'b0, ST_ON = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [VW-1:0]         disp_reg, disp_next;
  logic [VW-1:0]         pend_reg, pend_next;
  logic                  pend_flag_reg, pend_flag_next;
  logic [3:0]            nib_reg, nib_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  fd_reg, fd_next;
  logic                  boundary;
  logic                  lit;
  logic [3:0]            nib_arr [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib_arr[gi] = disp_next[4*gi +: 4];
    end
  endgenerate

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // upper_nz[k] is set when any nibble k..NUM_DIGITS-1 is non-zero
  logic [NUM_DIGITS-1:0] upper_nz;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign upper_nz[gi] = |nib_arr[gi];
      end else begin : g_rest
        assign upper_nz[gi] = (|nib_arr[gi]) | upper_nz[gi+1];
      end
    end
  endgenerate
  assign lit = (idx_next == '0) || upper_nz[idx_next];
`else
  assign lit = 1'b1;
`endif

  // State register; outputs are registered from next-state values so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_GAP;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      disp_reg      <= '0;
      pend_reg      <= '0;
      pend_flag_reg <= 1'b0;
      nib_reg       <= '0;
      an_reg        <= '1;
      fd_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      disp_reg      <= disp_next;
      pend_reg      <= pend_next;
      pend_flag_reg <= pend_flag_next;
      nib_reg       <= nib_next;
      an_reg        <= an_next;
      fd_reg        <= fd_next;
    end
  end

  // Next-state: scan sequencing plus pending/display data path
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg + 1'b1;
    boundary       = 1'b0;
    disp_next      = disp_reg;
    pend_next      = pend_reg;
    pend_flag_next = pend_flag_reg;
    case (state_reg)
      ST_GAP: begin
        if (cnt_reg == CW'(GAP - 1)) begin
          state_next = ST_ON;
          cnt_next   = '0;
        end
      end
      ST_ON: begin
        if (cnt_reg == CW'(DWELL - 1)) begin
          state_next = ST_GAP;
          cnt_next   = '0;
          if (idx_reg == IW'(NUM_DIGITS - 1)) begin
            idx_next = '0;
            boundary = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_GAP;
        cnt_next   = '0;
      end
    endcase
    if (boundary && pend_flag_reg) begin
      disp_next      = pend_reg;
      pend_flag_next = 1'b0;
    end
    // Acceptance only happens with pending empty, so it never races the load above
    if (val_valid && !pend_flag_reg) begin
      pend_next      = val_in;
      pend_flag_next = 1'b1;
    end
  end

  always_comb begin
    nib_next = nib_arr[idx_next];
    an_next  = '1;
    if (state_next == ST_ON && lit) begin
      an_next[idx_next] = 1'b0;
    end
    fd_next = (state_next == ST_ON) && (idx_next == IW'(NUM_DIGITS - 1)) &&
              (cnt_next == CW'(DWELL - 1));
  end

  assign val_ready  = ~pend_flag_reg;
  assign digit_nib  = nib_reg;
  assign digit_an   = an_reg;
  assign frame_done = fd_reg;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexes a packed multi-digit hex value onto one shared 7-segment decoder and a set of common-anode digit enables.
- Sits directly upstream of the hex-to-7-segment decoder.
- Its digit_nib output drives the decoder's 4-bit input.
- Its digit_an output drives the board anodes.
- New values arrive through a valid/ready handshake. They are applied only at frame boundaries so the display never tears.

Parameters:
- NUM_DIGITS, 4: number of displayed digits; value width is 4*NUM_DIGITS.
- DWELL, 50000: clock cycles per digit ON phase; must be >= 1.
- GAP, 2: all-anodes-off cycles before each digit, for ghost suppression; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- val_in  input  4*NUM_DIGITS  packed hex value; nibble k is digit k, and digit 0 is least significant.
- val_valid  input  1  producer offers val_in.
- val_ready  output  1  block can accept a value this cycle.
- digit_nib  output  4  nibble for the decoder's input.
- digit_an  output  NUM_DIGITS  active-low anode enables; at most one bit is low.
- frame_done  output  1  one-cycle pulse at the end of the last digit's ON phase.

Behaviour:
- Reset (synchronous, active-high):
  - state=GAP, digit index=0, phase counter=0.
  - Display register=0, pending register empty.
  - val_ready=1, digit_nib=0, digit_an=all 1s, frame_done=0.
- Acceptance:
  - A transfer occurs when val_valid && val_ready on a rising edge. val_in is captured into the pending register.
  - The pending flag is set and val_ready drops on the next cycle.
- Frame update:
  - Applies when the last digit (index NUM_DIGITS-1) completes its ON phase.
  - If pending is set, the display register loads the pending value in that same cycle, pending clears, and val_ready returns to 1 the next cycle.
  - If a transfer and a frame boundary coincide while pending is empty, the new value is captured to pending only. It is displayed from the following frame.
- State machine:
  - GAP: digit_an=all 1s, digit_nib=nibble of current index. After GAP cycles, go to ON with the phase counter cleared.
  - ON: digit_an bit[index]=0, others 1; digit_nib=display_reg[4*index+:4]. After DWELL cycles, go to GAP.
  - On the ON-to-GAP transition, index increments. It wraps from NUM_DIGITS-1 to 0, and frame_done pulses in that same cycle.
- Latency and frame length:
  - After a new value loads, its digit 0 appears at the first ON cycle of the next frame, GAP cycles after the load.
  - Frame length is NUM_DIGITS*(GAP+DWELL) cycles exactly.
- Outputs are registered; no combinational path exists from val_valid to any output except val_ready (itself registered).
- Reset asserted mid-frame returns everything to reset values on the next edge and discards pending data.
- Counter widths are sized by $clog2 of the parameter ranges. Counters never exceed their parameter minus 1.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- When defined, during ON the anode for digit k stays high (blank) if nibbles k..NUM_DIGITS-1 of the display register are all zero and k != 0.
  - Timing is unchanged; digit 0 is always lit.
  - frame_done is unaffected.
- When undefined, all digits are lit, including leading zeros.

Test Plan:
Bench uses NUM_DIGITS=4, DWELL=8, GAP=2.
- Reset: rst high 3 cycles, then low -> digit_an=4'b1111 for 2 cycles, then 4'b1110 with digit_nib=0 for 8 cycles. val_ready=1 throughout.
- Basic scan: load 16'h1A2F, wait one frame boundary -> next frame shows digit_an 1110/1101/1011/0111 with digit_nib F/2/A/1. Each digit is ON for 8 cycles, separated by 2 cycles of 4'b1111. frame_done pulses every 40 cycles.
- Back-pressure: offer 16'h1111 mid-frame, then 16'h2222 on the next cycle -> val_ready=0 after the first transfer, 16'h2222 is held off. At the boundary, display=1111 and val_ready returns to 1; 2222 is then accepted and shown one frame later.
- Boundary coincidence: with pending empty, transfer 16'hBEEF on the exact frame_done cycle -> the current boundary does not load it. Display changes to BEEF at the next frame_done.
- Mid-frame reset: assert rst while digit 2 is ON with pending=16'h5555 -> next cycle digit_an=1111, display=0, val_ready=1. 5555 never appears.
- Leading-zero (macro defined): display 16'h0030 -> digit_an shows 1110 and 1101 only. Slots 2 and 3 stay 1111 for their full 10 cycles; 16'h0000 lights digit 0 only.
